// File: rtl/plic_pkg.sv
// Shared address map, sizing helper and gateway state type for the multi-target PLIC.
package plic_pkg;

  localparam logic [21:0] PRIO_BASE     = 22'h000000;
  localparam logic [21:0] PEND_BASE     = 22'h001000;
  localparam logic [21:0] ENABLE_BASE   = 22'h002000;
  localparam logic [21:0] ENABLE_STRIDE = 22'h000080;
  localparam logic [21:0] CTX_BASE      = 22'h200000;
  localparam logic [21:0] CTX_STRIDE    = 22'h001000;
  localparam logic [21:0] CLAIM_OFS     = 22'h000004;

  function automatic int nwords(input int sources);
    return (sources + 31) / 32;
  endfunction

  typedef enum logic {
    GW_IDLE     = 1'b0,
    GW_INFLIGHT = 1'b1
  } gw_state_e;

endpackage

// File: rtl/plic_gateway.sv
// Per-source interrupt gateway: turns a level or edge line into a pending bit with claim/complete handshake.
//   state       | meaning
//   GW_IDLE     | may raise pending from the line
//   GW_INFLIGHT | claimed by a target, waiting for complete; edges are held one deep
module plic_gateway
  import plic_pkg::*;
#(
  parameter bit EDGE = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic i_src,
  input  logic i_claim,
  input  logic i_complete,
  input  logic i_is_edge,
  output logic o_pending
);

  gw_state_e r_state;
  gw_state_e w_state_nxt;
  logic      r_pending;
  logic      r_held;
  logic      r_src_q;
  logic      w_pending_nxt;
  logic      w_held_nxt;
  logic      w_edge;
  logic      w_rise;

  assign w_edge    = EDGE | i_is_edge;
  assign w_rise    = i_src & ~r_src_q;
  assign o_pending = r_pending;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= GW_IDLE;
      r_pending <= 1'b0;
      r_held    <= 1'b0;
      r_src_q   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_pending <= w_pending_nxt;
      r_held    <= w_held_nxt;
      r_src_q   <= i_src;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_pending_nxt = r_pending;
    w_held_nxt    = r_held;
    case (r_state)
      GW_IDLE: begin
        if (w_edge ? w_rise : i_src) w_pending_nxt = 1'b1;
        // a claim in the same cycle as a new request wins
        if (i_claim) begin
          w_pending_nxt = 1'b0;
          w_state_nxt   = GW_INFLIGHT;
        end
      end
      GW_INFLIGHT: begin
        if (w_edge && w_rise) w_held_nxt = 1'b1;
        if (i_complete) begin
          w_state_nxt   = GW_IDLE;
          w_held_nxt    = 1'b0;
          w_pending_nxt = w_edge ? (r_held | w_rise) : i_src;
        end
      end
      default: w_state_nxt = GW_IDLE;
    endcase
  end

endmodule

// File: rtl/plic_mt.sv
// Multi-target PLIC: register file, per-target priority selection, claim/complete and registered irq outputs.
module plic_mt
  import plic_pkg::*;
#(
  parameter int                 SOURCES   = 64,
  parameter int                 TARGETS   = 2,
  parameter int                 PRIO_W    = 3,
  parameter logic [SOURCES-1:0] EDGE_MASK = '0
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               req_i,
  input  logic [31:0]        addr_i,
  input  logic               we_i,
  input  logic [3:0]         be_i,
  input  logic [31:0]        wdata_i,
  output logic               rvalid_o,
  output logic [31:0]        rdata_o,
  input  logic [SOURCES-1:0] irq_sources_i,
  output logic [SOURCES-1:0] irq_pending_o,
  output logic [TARGETS-1:0] irq_o
);

  localparam int NW   = nwords(SOURCES);
  localparam int PW   = NW * 32;
  localparam int ID_W = $clog2(SOURCES);
  localparam logic [PW-1:0] ONE      = PW'(1);
  localparam logic [PW-1:0] SRC_MASK = ((ONE << SOURCES) - ONE) & ~ONE;

  logic [PRIO_W-1:0]  r_prio   [SOURCES];
  logic [PW-1:0]      r_enable [TARGETS];
  logic [PRIO_W-1:0]  r_thresh [TARGETS];
  logic [TARGETS-1:0] r_irq;
  logic               r_rvalid;
  logic [31:0]        r_rdata;

  logic [SOURCES-1:0] w_pending;
  logic [SOURCES-1:0] w_claim;
  logic [SOURCES-1:0] w_complete;
  logic [PW-1:0]      w_pend_pad;
  logic [ID_W-1:0]    w_cand_id   [TARGETS];
  logic [PRIO_W-1:0]  w_cand_prio [TARGETS];
  logic [21:0]        w_a;
  logic               w_rd, w_wr;
  logic               w_is_prio, w_is_pend, w_is_en, w_is_ctx, w_ofs_thr, w_ofs_claim;
  logic [31:0]        w_rdata;
  logic               w_unused;

  assign w_a         = addr_i[21:0];
  assign w_rd        = req_i & ~we_i;
  assign w_wr        = req_i & we_i & (be_i == 4'hF);
  assign w_is_prio   = (w_a[21:12] == PRIO_BASE[21:12]);
  assign w_is_pend   = (w_a[21:12] == PEND_BASE[21:12]);
  assign w_is_en     = (w_a[21:12] == ENABLE_BASE[21:12]);
  assign w_is_ctx    = (w_a[21] == CTX_BASE[21]);
  assign w_ofs_thr   = (w_a[11:0] == 12'h000);
  assign w_ofs_claim = (w_a[11:0] == CLAIM_OFS[11:0]);
  assign w_pend_pad  = PW'(w_pending);
  assign w_unused    = ^{addr_i[31:22], addr_i[1:0], irq_sources_i[0], w_claim[0], w_complete[0],
                         ENABLE_STRIDE[0], CTX_STRIDE[0]};

  assign w_pending[0] = 1'b0;
  for (genvar i = 1; i < SOURCES; i++) begin : g_gw
    plic_gateway #(.EDGE(EDGE_MASK[i])) u_gw (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .i_src      (irq_sources_i[i]),
      .i_claim    (w_claim[i]),
      .i_complete (w_complete[i]),
      .i_is_edge  (EDGE_MASK[i]),
      .o_pending  (w_pending[i])
    );
  end

  // strict '>' keeps the lowest ID on priority ties
  always_comb begin
    for (int t = 0; t < TARGETS; t++) begin
      w_cand_id[t]   = '0;
      w_cand_prio[t] = '0;
      for (int i = 1; i < SOURCES; i++) begin
        if (w_pending[i] && r_enable[t][i] && (r_prio[i] > w_cand_prio[t])) begin
          w_cand_prio[t] = r_prio[i];
          w_cand_id[t]   = ID_W'(i);
        end
      end
    end
  end

  always_comb begin
    w_claim    = '0;
    w_complete = '0;
    w_rdata    = '0;
    if (w_is_prio)
      for (int i = 1; i < SOURCES; i++)
        if (int'(w_a[11:2]) == i) w_rdata = 32'(r_prio[i]);
    if (w_is_pend)
      for (int w = 0; w < NW; w++)
        if (int'(w_a[11:2]) == w) w_rdata = w_pend_pad[w*32 +: 32];
    if (w_is_en)
      for (int t = 0; t < TARGETS; t++)
        for (int w = 0; w < NW; w++)
          if (int'(w_a[11:7]) == t && int'(w_a[6:2]) == w) w_rdata = r_enable[t][w*32 +: 32];
    if (w_is_ctx) begin
      for (int t = 0; t < TARGETS; t++) begin
        if (int'(w_a[20:12]) == t) begin
          if (w_ofs_thr) w_rdata = 32'(r_thresh[t]);
          if (w_ofs_claim) begin
            w_rdata = 32'(w_cand_id[t]);
            if (w_rd && (w_cand_prio[t] != '0)) w_claim[w_cand_id[t]] = 1'b1;
            for (int i = 1; i < SOURCES; i++)
              if (w_wr && (wdata_i == 32'(i)) && r_enable[t][i]) w_complete[i] = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < SOURCES; i++) r_prio[i] <= '0;
      for (int t = 0; t < TARGETS; t++) begin
        r_enable[t] <= '0;
        r_thresh[t] <= '0;
      end
      r_irq    <= '0;
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
    end else begin
      r_rvalid <= req_i;
      r_rdata  <= w_rd ? w_rdata : 32'd0;
      for (int t = 0; t < TARGETS; t++)
        r_irq[t] <= (w_cand_prio[t] != '0) && (w_cand_prio[t] > r_thresh[t]);
      if (w_wr) begin
        if (w_is_prio)
          for (int i = 1; i < SOURCES; i++)
            if (int'(w_a[11:2]) == i) r_prio[i] <= wdata_i[PRIO_W-1:0];
        if (w_is_en)
          for (int t = 0; t < TARGETS; t++)
            for (int w = 0; w < NW; w++)
              if (int'(w_a[11:7]) == t && int'(w_a[6:2]) == w)
                r_enable[t][w*32 +: 32] <= wdata_i & SRC_MASK[w*32 +: 32];
        if (w_is_ctx && w_ofs_thr)
          for (int t = 0; t < TARGETS; t++)
            if (int'(w_a[20:12]) == t) r_thresh[t] <= wdata_i[PRIO_W-1:0];
      end
    end
  end

  assign rvalid_o      = r_rvalid;
  assign rdata_o       = r_rdata;
  assign irq_o         = r_irq;
  assign irq_pending_o = w_pending;

endmodule

// File: tb/tb_plic_mt.sv
// Directed self-checking bench for plic_mt: bus timing, gateways, selection, claim/complete and ignored writes.
module tb_plic_mt;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        req_i = 1'b0;
  logic [31:0] addr_i = '0;
  logic        we_i = 1'b0;
  logic [3:0]  be_i = '0;
  logic [31:0] wdata_i = '0;
  logic        rvalid_o;
  logic [31:0] rdata_o;
  logic [63:0] src = '0;
  logic [63:0] pend;
  logic [1:0]  irq;
  logic [31:0] dummy;
  int          total = 0;
  int          bad = 0;

  always #5 clk_i = ~clk_i;

  plic_mt #(
    .SOURCES(64), .TARGETS(2), .PRIO_W(3), .EDGE_MASK(64'h80)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .addr_i(addr_i), .we_i(we_i),
    .be_i(be_i), .wdata_i(wdata_i), .rvalid_o(rvalid_o), .rdata_o(rdata_o),
    .irq_sources_i(src), .irq_pending_o(pend), .irq_o(irq)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic bus(input logic [31:0] a, input logic w, input logic [31:0] d,
                     input logic [3:0] be, output logic [31:0] rd);
    req_i = 1'b1; addr_i = a; we_i = w; wdata_i = d; be_i = be;
    @(posedge clk_i);
    #1;
    req_i = 1'b0; we_i = 1'b0;
    check("rvalid", {63'd0, rvalid_o}, 64'd1);
    rd = rdata_o;
    if (w) check("wr_rdata", {32'd0, rdata_o}, 64'd0);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus(a, 1'b1, d, 4'hF, dummy);
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] v;
    bus(a, 1'b0, 32'd0, 4'hF, v);
    check(tag, {32'd0, v}, {32'd0, exp});
  endtask

  initial begin
    // reset
    tick(3);
    rst_ni = 1'b1;
    tick(1);
    check("rst_irq", {62'd0, irq}, 64'd0);
    check("rst_rvalid", {63'd0, rvalid_o}, 64'd0);
    check("rst_rdata", {32'd0, rdata_o}, 64'd0);
    check("rst_pend", pend, 64'd0);

    // 1: empty claims
    rd_chk("claim0_empty", 32'h200004, 32'd0);
    rd_chk("claim1_empty", 32'h201004, 32'd0);
    tick(1);
    check("rvalid_idle", {63'd0, rvalid_o}, 64'd0);
    check("irq_idle", {62'd0, irq}, 64'd0);

    // 2: two level sources at equal priority
    wr(32'h14, 32'd3);
    wr(32'h24, 32'd3);
    wr(32'h2000, 32'h220);
    wr(32'h200000, 32'd1);
    src[5] = 1'b1; src[9] = 1'b1;
    tick(1);
    check("pend_5_9", pend, 64'h220);
    check("irq_lat1", {62'd0, irq}, 64'd0);
    tick(1);
    check("irq_lat2", {62'd0, irq}, 64'd1);
    rd_chk("claim_5", 32'h200004, 32'd5);
    rd_chk("claim_9", 32'h200004, 32'd9);
    rd_chk("claim_none", 32'h200004, 32'd0);
    check("irq_fall", {62'd0, irq}, 64'd0);

    // 3: level re-pend on complete
    wr(32'h200004, 32'd5);
    check("level_repend", {63'd0, pend[5]}, 64'd1);
    src[5] = 1'b0;
    rd_chk("claim_5b", 32'h200004, 32'd5);
    wr(32'h200004, 32'd5);
    tick(2);
    check("level_no_repend", {63'd0, pend[5]}, 64'd0);
    rd_chk("claim_empty2", 32'h200004, 32'd0);

    // 4: edge source 7 with held edge
    wr(32'h1C, 32'd2);
    wr(32'h2000, 32'h2A0);
    src[7] = 1'b1; tick(1);
    src[7] = 1'b0; tick(1);
    check("edge_pend", {63'd0, pend[7]}, 64'd1);
    rd_chk("claim_7", 32'h200004, 32'd7);
    src[7] = 1'b1; tick(1);
    src[7] = 1'b0; tick(1);
    src[7] = 1'b1; tick(1);
    src[7] = 1'b0; tick(1);
    check("edge_inflight", {63'd0, pend[7]}, 64'd0);
    wr(32'h200004, 32'd7);
    check("edge_held_repend", {63'd0, pend[7]}, 64'd1);
    rd_chk("claim_7b", 32'h200004, 32'd7);
    wr(32'h200004, 32'd7);
    tick(2);
    check("edge_clear", {63'd0, pend[7]}, 64'd0);

    // 5: target 1 threshold gating
    wr(32'hA0, 32'd2);
    wr(32'h2084, 32'h100);
    wr(32'h201000, 32'd2);
    src[40] = 1'b1;
    tick(3);
    check("irq_thresh_block", {62'd0, irq}, 64'd0);
    rd_chk("claim_40", 32'h201004, 32'd40);
    wr(32'h201004, 32'd40);
    wr(32'h201000, 32'd1);
    check("irq_thresh_lat", {62'd0, irq}, 64'd0);
    tick(1);
    check("irq_t1", {62'd0, irq}, 64'd2);

    // 6: ignored writes
    wr(32'h201004, 32'd9);
    tick(2);
    check("complete_wrong_tgt", {63'd0, pend[9]}, 64'd0);
    wr(32'h0, 32'd7);
    rd_chk("prio0", 32'h0, 32'd0);
    bus(32'h14, 1'b1, 32'd6, 4'h3, dummy);
    rd_chk("prio5_partial", 32'h14, 32'd3);
    wr(32'h100, 32'd5);
    rd_chk("prio64", 32'h100, 32'd0);
    rd_chk("en0_w0", 32'h2000, 32'h2A0);
    wr(32'h2080, 32'h1);
    rd_chk("en1_bit0", 32'h2080, 32'd0);
    rd_chk("pend_w0", 32'h1000, 32'd0);
    rd_chk("pend_w1", 32'h1004, 32'h100);
    rd_chk("thresh1", 32'h201000, 32'd1);
    rd_chk("unmapped", 32'h3000, 32'd0);
    wr(32'h200004, 32'd9);
    check("complete_9_t0", {63'd0, pend[9]}, 64'd1);

    // reset mid-operation
    rst_ni = 1'b0;
    tick(2);
    check("midrst_pend", pend, 64'd0);
    check("midrst_irq", {62'd0, irq}, 64'd0);
    rst_ni = 1'b1;
    tick(2);
    check("post_rst_repend", pend, (64'd1 << 9) | (64'd1 << 40));
    rd_chk("post_rst_prio", 32'h24, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/plic_mt.md
Name: plic_mt

Overview:
- Multi-target, multi-word successor to the single-target Verilator PLIC model.
- Adds level/edge gateways, true claim/complete semantics with in-flight tracking, and per-target enables and thresholds.
- Sits on the demo-system device bus as a slave and drives irq_o[t] to each hart's external-interrupt input.
- Used in both the Verilator top and FPGA builds.

Parameters:
- SOURCES, 64: interrupt IDs 0..SOURCES-1. ID 0 is reserved and never pending. Legal range is 2..1024.
- TARGETS, 2: number of interrupt targets (contexts). Legal range is 1..8.
- PRIO_W, 3: priority width in bits. Priority 0 means never interrupt.
- EDGE_MASK, '0 (width SOURCES): bit i = 1 makes source i edge-triggered; 0 makes it level-triggered.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous, active-low reset
- req_i  in  1  bus request, single cycle
- addr_i  in  32  byte address; bits [21:0] are decoded
- we_i  in  1  write enable
- be_i  in  4  byte enables
- wdata_i  in  32  write data
- rvalid_o  out  1  response valid
- rdata_o  out  32  read data, registered
- irq_sources_i  in  SOURCES  raw interrupt lines; bit 0 is ignored
- irq_pending_o  out  SOURCES  pending vector, for debug
- irq_o  out  TARGETS  per-target interrupt request

Behaviour:
- Reset: all priorities, enables, thresholds, pending and in-flight bits clear. rvalid_o=0, rdata_o=0, irq_o=0.
- Register map (word aligned; partial writes with be_i != 4'hF are ignored; unmapped reads return 0 and unmapped writes are ignored):
  - Priority: 0x000000 + 4*id. ID 0 and id >= SOURCES read 0 and ignore writes.
  - Pending: 0x001000 + 4*w, read-only.
  - Enable: 0x002000 + 0x80*t + 4*w. Bit 0 of word 0 is hardwired 0.
  - Threshold: 0x200000 + 0x1000*t.
  - Claim/complete: 0x200004 + 0x1000*t.
- Bus response: rvalid_o=1 exactly one cycle after every req_i, including writes. rdata_o is valid in that same cycle and 0 for writes. Back-to-back requests are supported.
- Gateway, per source, with state {IDLE, INFLIGHT}:
  - Level source: in IDLE with the line high, set pending. At claim, clear pending and go to INFLIGHT. At complete, return to IDLE; if the line is still high, pending re-asserts on the next cycle.
  - Edge source: a 0->1 transition (one sampling register) in IDLE sets pending. An edge seen in INFLIGHT sets a one-deep held bit. At complete, a held edge re-raises pending on the next cycle and clears the held bit. Further edges while held is set are dropped.
  - A source disabled for all targets still becomes pending; enables only gate selection.
- Selection, per target t: the candidate is the highest-priority source with pending=1, enable[t]=1 and prio > 0. Ties go to the lowest ID. irq_o[t] = candidate exists && prio > threshold[t]. irq_o is registered, so it asserts 1 cycle after pending/enable/threshold changes and 2 cycles after a level input rises.
- Claim (read of claim reg t):
  - Returns the candidate ID, or 0 if none. The threshold is not applied to claim reads.
  - At the request cycle the claimed source's pending bit clears and it enters INFLIGHT.
  - If pending set and claim of the same source coincide, claim wins.
  - A claim returning 0 has no side effect.
- Complete (write of ID to claim reg t):
  - Takes effect only if the ID is < SOURCES, is INFLIGHT, and enable[t][ID]=1. Otherwise it is silently ignored.
  - Complete of ID 0 is ignored.
- Reset mid-operation: all gateway state is lost; sources still asserted re-pend after release.

Decomposition:
- plic_pkg holds the base/stride localparams (PRIO_BASE, PEND_BASE, ENABLE_BASE/STRIDE, CTX_BASE/STRIDE, CLAIM_OFS), the NWORDS = ceil(SOURCES/32) function and gw_state_e {GW_IDLE, GW_INFLIGHT}.
- Sub-module plic_gateway (one instance per source, parameter EDGE) owns pending, in-flight, held and edge-sample state. Its inputs are src, claim, complete and is_edge; its output is pending.

Test Plan:
1. Reset, then read 0x200004 for t0 and t1 -> both return 0; irq_o=2'b00; rvalid_o pulses one cycle after each req.
2. prio[5]=3, prio[9]=3, enable t0 word0=0x220, thresh0=1, raise src 5 and 9 (level) -> irq_o[0]=1 two cycles later. Claim returns 5, then 9. A third claim returns 0 and irq_o[0] falls.
3. Level src 5 held high: claim 5, complete 5 -> pending[5] re-asserts the cycle after complete. Drop src 5, claim, complete -> pending stays 0.
4. EDGE_MASK bit 7 set: pulse src7, claim 7, pulse src7 twice during INFLIGHT -> after complete, exactly one new pending[7]. A second claim/complete leaves pending clear.
5. t1 enables only src 40 (word1=0x100) with prio 2, thresh1=2 -> irq_o[1]=0 while a claim read still returns 40. Set thresh1=1 -> irq_o[1]=1 one cycle later.
6. Complete 9 from t1 (not enabled there), write prio[0]=7, write with be_i=4'h3 -> all ignored. Readback shows unchanged values; prio[0] reads 0.
